// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: valid/ready stream carrying a DATA_W-bit bundle.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of STAGES registered slots with flush and occupancy.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter bit FLUSH_CLEARS_DATA = 1'b1,
  localparam int CNT_W = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipe_stage_chain_if.slave   up,
  pipe_stage_chain_if.master  dn,
  output logic [CNT_W-1:0]    occupancy
);
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] r;
  logic [DATA_W-1:0] d [STAGES];
  logic              in_fire;
  logic              out_fire;
  // A slot can advance if it is empty or every slot ahead of it up to the output is moving.
  for (genvar g = 0; g < STAGES; g++) begin : g_ready
    assign r[g] = ~(&v[STAGES-1:g]) | dn.ready;
  end
  assign up.ready  = r[0] & ~flush & rst_n;
  assign dn.valid  = v[STAGES-1] & ~flush;
  assign dn.data   = d[STAGES-1];
  assign in_fire   = up.valid & up.ready;
  assign out_fire  = dn.valid & dn.ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else if (flush) begin
      v         <= '0;
      occupancy <= '0;
      if (FLUSH_CLEARS_DATA) for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      if (r[0]) begin
        v[0] <= in_fire;
        if (in_fire) d[0] <= up.data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
      occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed vector table, async reset sequence and random run against a queue model.
module tb_pipe_stage_chain;
  localparam int S = 3;
  localparam int W = 32;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occupancy;
  int checks = 0;
  int errors = 0;
  pipe_stage_chain_if #(.DATA_W(W)) up_if ();
  pipe_stage_chain_if #(.DATA_W(W)) dn_if ();
  pipe_stage_chain #(.DATA_W(W), .STAGES(S), .FLUSH_CLEARS_DATA(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up_if), .dn(dn_if), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  // Model: queue of in-flight entries, oldest first, each with its slot position.
  typedef struct { logic [W-1:0] d; int pos; } ent_t;
  ent_t q[$];
  logic [W-1:0] last_out = '0;
  logic exp_ir, exp_ov;
  logic [W-1:0] exp_od;
  int exp_occ;
  typedef struct { int iv; int id; int ordy; int fl; int ir; int ov; int od; int occ; } vec_t;
  vec_t vq[$];
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask
  // Each entry slides one slot forward, but never onto a slot still held by the entry ahead.
  function automatic bit advance(inout ent_t m[$], inout logic [W-1:0] lo, input bit ordy);
    int prev = S;
    int np;
    if (m.size() > 0 && m[0].pos == S - 1 && ordy) void'(m.pop_front());
    foreach (m[k]) begin
      np = (m[k].pos + 1 < prev - 1) ? m[k].pos + 1 : prev - 1;
      if (np == S - 1 && m[k].pos != S - 1) lo = m[k].d;
      m[k].pos = np;
      prev = np;
    end
    return m.size() == 0 || m[m.size()-1].pos > 0;
  endfunction
  task automatic predict();
    ent_t t[$] = q;
    logic [W-1:0] lo = last_out;
    bit free = advance(t, lo, dn_if.ready);
    exp_ir  = rst_n && !flush && free;
    exp_ov  = !flush && q.size() > 0 && q[0].pos == S - 1;
    exp_od  = last_out;
    exp_occ = q.size();
  endtask
  task automatic commit();
    bit free;
    if (flush) begin
      q.delete();
      last_out = '0;
    end else begin
      free = advance(q, last_out, dn_if.ready);
      if (up_if.valid && free) q.push_back('{up_if.data, 0});
    end
  endtask
  task automatic apply(input int iv, input int id, input int ordy, input int fl);
    up_if.valid = 1'(iv);
    up_if.data  = W'(id);
    dn_if.ready = 1'(ordy);
    flush       = 1'(fl);
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask
  task automatic v(input int iv, input int id, input int ordy, input int fl,
                   input int ir, input int ov, input int od, input int occ);
    vq.push_back('{iv, id, ordy, fl, ir, ov, od, occ});
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
  initial begin
    apply(0, 0, 0, 0);
    #2;
    chk("reset_in_ready", 32'(up_if.ready), 0);
    chk("reset_out_valid", 32'(dn_if.valid), 0);
    chk("reset_occ", 32'(occupancy), 0);
    chk("reset_out_data", dn_if.data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // iv id ordy fl | in_ready out_valid out_data occupancy
    v(1, 'h11, 1, 0, 1, 0, 'h00, 0); v(1, 'h22, 1, 0, 1, 0, 'h00, 1);
    v(1, 'h33, 1, 0, 1, 0, 'h00, 2); v(0, 0, 1, 0, 1, 1, 'h11, 3);
    v(0, 0, 1, 0, 1, 1, 'h22, 2);    v(0, 0, 1, 0, 1, 1, 'h33, 1);
    v(0, 0, 1, 0, 1, 0, 'h33, 0);
    v(1, 'hA0, 0, 0, 1, 0, 'h33, 0); v(1, 'hA1, 0, 0, 1, 0, 'h33, 1);
    v(1, 'hA2, 0, 0, 1, 0, 'h33, 2); v(1, 'hA3, 0, 0, 0, 1, 'hA0, 3);
    v(1, 'hA3, 1, 0, 1, 1, 'hA0, 3); v(1, 'hA4, 1, 0, 1, 1, 'hA1, 3);
    v(0, 0, 1, 0, 1, 1, 'hA2, 3);    v(0, 0, 1, 0, 1, 1, 'hA3, 2);
    v(0, 0, 1, 0, 1, 1, 'hA4, 1);    v(0, 0, 1, 0, 1, 0, 'hA4, 0);
    v(1, 'h01, 0, 0, 1, 0, 'hA4, 0); v(0, 0, 0, 0, 1, 0, 'hA4, 1);
    v(1, 'h02, 0, 0, 1, 0, 'hA4, 1); v(0, 0, 0, 0, 1, 1, 'h01, 2);
    v(0, 0, 0, 0, 1, 1, 'h01, 2);
    v(1, 'h03, 0, 0, 1, 1, 'h01, 2); v(1, 'hFF, 1, 1, 0, 0, 'h01, 3);
    v(0, 0, 1, 0, 1, 0, 'h00, 0);
    foreach (vq[i]) begin
      apply(vq[i].iv, vq[i].id, vq[i].ordy, vq[i].fl);
      chk($sformatf("vec%0d_in_ready", i), 32'(up_if.ready), W'(vq[i].ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(dn_if.valid), W'(vq[i].ov));
      chk($sformatf("vec%0d_out_data", i), dn_if.data, W'(vq[i].od));
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), W'(vq[i].occ));
      tick();
    end
    apply(1, 'h55, 0, 0); tick();
    apply(1, 'h66, 0, 0); tick();
    apply(0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(dn_if.valid), 0);
    chk("async_rst_in_ready", 32'(up_if.ready), 0);
    chk("async_rst_occ", 32'(occupancy), 0);
    q.delete();
    last_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 'h77, 1, 0);
    chk("post_rst_in_ready", 32'(up_if.ready), 1);
    tick();
    apply(0, 0, 1, 0);
    chk("post_rst_lat1", 32'(dn_if.valid), 0);
    tick();
    chk("post_rst_lat2", 32'(dn_if.valid), 0);
    tick();
    chk("post_rst_lat3_valid", 32'(dn_if.valid), 1);
    chk("post_rst_lat3_data", dn_if.data, 'h77);
    tick();
    chk("post_rst_drained", 32'(occupancy), 0);
    for (int i = 0; i < 1500; i++) begin
      apply(int'($urandom_range(0, 3) != 0), int'($urandom), int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 24) == 0));
      predict();
      chk("rand_in_ready", 32'(up_if.ready), 32'(exp_ir));
      chk("rand_out_valid", 32'(dn_if.valid), 32'(exp_ov));
      chk("rand_out_data", dn_if.data, exp_od);
      chk("rand_occ", 32'(occupancy), W'(exp_occ));
      chk("rand_occ_bound", 32'(occupancy <= 2'(S)), 1);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic replacement for the fixed IF_ID/ID_EX/EX_MEM/MEM_WB latch style.
- A chain of STAGES registered slots carries a DATA_W-bit bundle, with a valid/ready handshake at both ends.
- Bubbles collapse: a slot may accept a new entry whenever it is empty.
- Supports synchronous flush (branch/jump squash) and reports live occupancy. Sits between any two datapath stages of the RV32IM core.

Parameters:
- DATA_W, 32: width of the carried bundle.
- STAGES, 2: number of register slots. Legal range 1..8.
- FLUSH_CLEARS_DATA, 1: 1 zeroes slot data on flush; 0 clears only the valid bits.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous squash of all slots.
- IN_VALID  in  1  upstream has data.
- IN_DATA  in  DATA_W  upstream bundle.
- IN_READY  out  1  chain can accept this cycle.
- OUT_VALID  out  1  slot STAGES-1 holds valid data.
- OUT_DATA  out  DATA_W  contents of slot STAGES-1.
- OUT_READY  in  1  downstream accepts.
- OCCUPANCY  out  CNT_W  number of valid slots; CNT_W = $clog2(STAGES+1).

Behaviour:
- State per slot i (0..STAGES-1): V[i] valid bit, D[i] data register.
- Reset (RST=0, async):
  - All V=0, all D=0, OCCUPANCY=0.
  - IN_READY=0 and OUT_VALID=0 while RST=0.
  - Reset released mid-transfer: all in-flight entries are lost; no partial state survives.
- Ready chain (combinational):
  - R[STAGES-1] = ~V[STAGES-1] | OUT_READY.
  - R[i] = ~V[i] | R[i+1].
  - IN_READY = R[0] & ~FLUSH & RST.
- Fire conditions:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY.
  - OUT_VALID = V[STAGES-1] & ~FLUSH.
- Advance, each edge with FLUSH=0:
  - Slot i>0: if R[i], then V[i] <= V[i-1] and D[i] <= D[i-1] (D updated only when V[i-1]=1).
  - Slot 0: if R[0], then V[0] <= in_fire and D[0] <= IN_DATA (only when in_fire).
  - A slot with R[i]=0 holds V and D unchanged (stall).
- Latency: with no back-pressure, data accepted at edge n appears on OUT_DATA after edge n+STAGES-1 and is consumed at edge n+STAGES. Throughput is 1 entry/cycle sustained.
- Back-pressure: with OUT_READY=0, entries compress toward the output. IN_READY drops only when all STAGES slots are valid. Full: OCCUPANCY=STAGES.
- Simultaneous in_fire and out_fire when full: permitted (R chain passes through). Occupancy stays STAGES.
- FLUSH=1:
  - Next edge, all V <= 0; D <= 0 if FLUSH_CLEARS_DATA=1, else D holds.
  - In the flush cycle no handshake occurs on either side (IN_READY=0, OUT_VALID=0).
  - OCCUPANCY <= 0. FLUSH overrides every other event.
- OCCUPANCY: registered.
  - OCC <= OCC + in_fire - out_fire.
  - Never exceeds STAGES and never underflows; an assertion in the bench checks this.
  - Always equals popcount(V).
- OUT_DATA: always D[STAGES-1], regardless of V.
- STAGES=1: degenerates to a single elastic register with pass-through ready; same rules apply.

Test Plan:
- STAGES=3, OUT_READY=1, feed 0x11,0x22,0x33 on consecutive cycles → OUT_VALID first high 2 edges after first accept; outputs 0x11,0x22,0x33 on consecutive cycles; OCCUPANCY peaks at 3.
- STAGES=3, OUT_READY=0, stream 0xA0..0xA4 → 3 accepted, IN_READY=0 from the cycle OCCUPANCY=3; release OUT_READY → 0xA0,0xA1,0xA2 then 0xA3,0xA4 with no loss or duplication.
- Bubble collapse, STAGES=3: accept 0x01, idle 1 cycle, accept 0x02, OUT_READY=0 → slots fill contiguously at the output end; OCCUPANCY=2, IN_READY=1.
- FLUSH with 3 valid entries while IN_VALID=1 (0xFF) → IN_READY=0 and OUT_VALID=0 in that cycle; next cycle OCCUPANCY=0, OUT_VALID=0; OUT_DATA=0 (FLUSH_CLEARS_DATA=1) or the last value (=0); 0xFF not captured.
- Full chain, IN_VALID=1 and OUT_READY=1 in the same cycle → one out, one in; OCCUPANCY stays 3; order preserved.
- Assert RST=0 asynchronously mid-stream (between edges) → OUT_VALID, IN_READY and OCCUPANCY go 0 immediately; after release, first accepted word emerges with normal STAGES latency.
